// File: rtl/genius_pkg.sv
// genius_pkg: shared state encoding, LFSR constants and speed codes for the Genius sequence player
package genius_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ALIGN = 2'd1;
  localparam logic [1:0] S_ON    = 2'd2;
  localparam logic [1:0] S_OFF   = 2'd3;
  localparam logic [1:0] SPD_025 = 2'd0;
  localparam logic [1:0] SPD_05  = 2'd1;
  localparam logic [1:0] SPD_1   = 2'd2;
  localparam logic [1:0] SPD_2   = 2'd3;
  // Fibonacci taps at bits 15, 13, 12 and 10
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction
  function automatic logic [3:0] colour(input logic [15:0] l);
    return 4'b0001 << l[1:0];
  endfunction
endpackage

// File: rtl/rate_tick_sel.sv
// rate_tick_sel: selects one slow square wave and emits a one-cycle tick on each rising edge
module rate_tick_sel
  import genius_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] src,
  input  logic [1:0] sel,
  output logic       tick
);
  logic [3:0] hist, rise;
  // Edges are detected on every input before the mux, so changing sel never fakes an edge
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      hist <= '0;
      rise <= '0;
    end else begin
      hist <= src;
      rise <= src & ~hist;
    end
  assign tick = sel == SPD_025 ? rise[0] :
                sel == SPD_05  ? rise[1] :
                sel == SPD_1   ? rise[2] :
                (sel == SPD_2) && rise[3];
endmodule

// File: rtl/genius_sequence_player.sv
// genius_sequence_player: plays a pseudo-random one-hot LED sequence paced by a selectable slow clock
module genius_sequence_player #(
  parameter int          MAX_LEN      = 16,
  parameter logic [15:0] DEFAULT_SEED = genius_pkg::DEFAULT_SEED
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        C025Hz,
  input  logic        C05Hz,
  input  logic        C1Hz,
  input  logic        C2Hz,
  input  logic        start,
  input  logic [1:0]  speed,
  input  logic [4:0]  seq_len,
  input  logic [15:0] seed,
  output logic [3:0]  led,
  output logic        busy,
  output logic        done,
  output logic [3:0]  step_idx
);
  import genius_pkg::*;
  localparam logic [4:0] MAX_L = 5'(MAX_LEN);
  logic [1:0]  state, speed_r;
  logic [4:0]  len_r, len_in;
  logic [15:0] lfsr;
  logic        tick_raw, tick, last;
  rate_tick_sel u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .src      ({C2Hz, C1Hz, C05Hz, C025Hz}),
    .sel      (speed_r),
    .tick     (tick_raw)
  );
  assign tick   = tick_raw && (state != S_IDLE);
  assign last   = {1'b0, step_idx} == len_r - 5'd1;
  assign len_in = seq_len == 5'd0 ? 5'd1 : seq_len > MAX_L ? MAX_L : seq_len;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state    <= S_IDLE;
      speed_r  <= SPD_025;
      len_r    <= 5'd1;
      lfsr     <= DEFAULT_SEED;
      led      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      step_idx <= '0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        if (start) begin
          state    <= S_ALIGN;
          speed_r  <= speed;
          len_r    <= len_in;
          lfsr     <= seed == 16'd0 ? DEFAULT_SEED : seed;
          busy     <= 1'b1;
          step_idx <= '0;
        end
      end else if (tick) begin
        if (state == S_ALIGN) begin
          state <= S_ON;
          led   <= colour(lfsr);
        end else if (state == S_ON) begin
          state <= S_OFF;
          led   <= '0;
          lfsr  <= lfsr_next(lfsr);
        end else if (last) begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state    <= S_ON;
          step_idx <= step_idx + 4'd1;
          led      <= colour(lfsr);
        end
      end
    end
endmodule

// File: tb/tb_genius_sequence_player.sv
// tb_genius_sequence_player: directed scoreboard bench for the Genius sequence player
module tb_genius_sequence_player;
  logic        CLOCK_50 = 0, reset = 1, start = 0;
  logic        C025Hz = 0, C05Hz = 0, C1Hz = 0, C2Hz = 0;
  logic [1:0]  speed = 0;
  logic [4:0]  seq_len = 0;
  logic [15:0] seed = 0;
  logic [3:0]  led, step_idx;
  logic        busy, done;
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, last_chg = 0, first_chg = -1;
  int spacing = 0, start_cyc = 0;
  bit mon_en = 0;
  logic [3:0] prev_led = 0;
  typedef struct packed {logic [3:0] led; logic [3:0] step;} exp_t;
  exp_t q[$];
  exp_t e;

  genius_sequence_player dut (
    .CLOCK_50 (CLOCK_50), .reset (reset),
    .C025Hz (C025Hz), .C05Hz (C05Hz), .C1Hz (C1Hz), .C2Hz (C2Hz),
    .start (start), .speed (speed), .seq_len (seq_len), .seed (seed),
    .led (led), .busy (busy), .done (done), .step_idx (step_idx)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Slow waves with periods 64/32/16/8 cycles, derived from a free-running cycle count
  initial forever begin
    @(posedge CLOCK_50);
    #1;
    cyc++;
    {C025Hz, C05Hz, C1Hz, C2Hz} = {cyc[5], cyc[4], cyc[3], cyc[2]};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (mon_en) begin
      if (led !== prev_led) begin
        chk("led_change_expected", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("led", 32'(led), 32'(e.led));
          chk("step_idx", 32'(step_idx), 32'(e.step));
          if (first_chg < 0) first_chg = cyc;
          else chk("tick_spacing", cyc - last_chg, spacing);
        end
        last_chg = cyc;
      end
      if (done) begin
        done_cnt++;
        chk("busy_low_at_done", 32'(busy), 0);
        chk("done_spacing", cyc - last_chg, spacing);
      end
    end
    prev_led = led;
  end

  task automatic push_run(input logic [15:0] sd, input int n);
    logic [15:0] l;
    l = sd == 16'd0 ? 16'hACE1 : sd;
    for (int i = 0; i < n; i++) begin
      q.push_back({4'b0001 << l[1:0], 4'(i)});
      q.push_back({4'b0000, 4'(i)});
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
  endtask

  task automatic pulse_start(input logic [1:0] sp, input logic [4:0] ln, input logic [15:0] sd, input int align);
    @(negedge CLOCK_50);
    while (align >= 0 && (cyc % (64 >> sp)) != align) @(negedge CLOCK_50);
    speed = sp;
    seq_len = ln;
    seed = sd;
    start = 1;
    start_cyc = cyc;
    @(negedge CLOCK_50);
    start = 0;
  endtask

  task automatic arm_start(input logic [1:0] sp, input logic [4:0] ln, input logic [15:0] sd, input int align);
    spacing = 64 >> sp;
    first_chg = -1;
    done_cnt = 0;
    pulse_start(sp, ln, sd, align);
    chk("busy_after_start", 32'(busy), 1);
  endtask

  task automatic finish_run(input int n, input string tag);
    int k = 0;
    while (busy && k < 5000) begin
      @(negedge CLOCK_50);
      k++;
    end
    chk({tag, "_finished"}, 32'(busy), 0);
    @(negedge CLOCK_50);
    chk({tag, "_queue_empty"}, q.size(), 0);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_final_step"}, 32'(step_idx), n - 1);
  endtask

  task automatic wait_led_on();
    int k = 0;
    while (led == 4'd0 && k < 500) begin
      @(negedge CLOCK_50);
      k++;
    end
    chk("led_on_seen", 32'(led != 4'd0), 1);
  endtask

  initial begin
    int sp_done, sp_led;
    repeat (3) @(negedge CLOCK_50);
    chk("reset_led", 32'(led), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_step", 32'(step_idx), 0);
    reset = 0;
    mon_en = 1;
    // Known sequence from seed 1: 0010, 0, 0100, 0, 0001, 0
    q.delete();
    q.push_back({4'b0010, 4'd0}); q.push_back({4'b0000, 4'd0});
    q.push_back({4'b0100, 4'd1}); q.push_back({4'b0000, 4'd1});
    q.push_back({4'b0001, 4'd2}); q.push_back({4'b0000, 4'd2});
    arm_start(2'd3, 5'd3, 16'h0001, -1);
    finish_run(3, "seed1");
    for (int s = 0; s < 4; s++) begin
      q.delete();
      push_run(16'h0001, 3);
      arm_start(2'(s), 5'd3, 16'h0001, -1);
      finish_run(3, "speed");
    end
    q.delete();
    push_run(16'hBEEF, 1);
    arm_start(2'd3, 5'd0, 16'hBEEF, -1);
    finish_run(1, "len0");
    q.delete();
    push_run(16'h5A5A, 16);
    arm_start(2'd3, 5'd31, 16'h5A5A, -1);
    finish_run(16, "len31");
    q.delete();
    push_run(16'h0000, 2);
    arm_start(2'd3, 5'd2, 16'h0000, -1);
    finish_run(2, "seed0");
    // A second start during ON must not disturb the run in progress
    q.delete();
    push_run(16'h0001, 3);
    arm_start(2'd3, 5'd3, 16'h0001, -1);
    wait_led_on();
    pulse_start(2'd0, 5'd7, 16'h1234, -1);
    finish_run(3, "busy_start");
    // Start lands in the cycle where the C2Hz tick is present
    q.delete();
    push_run(16'h0001, 2);
    arm_start(2'd3, 5'd2, 16'h0001, 5);
    finish_run(2, "coincident");
    chk("coincident_first_on", first_chg - start_cyc, 9);
    // Reset while the first step is lit
    q.delete();
    push_run(16'h0001, 3);
    arm_start(2'd3, 5'd3, 16'h0001, -1);
    wait_led_on();
    mon_en = 0;
    reset = 1;
    #1;
    chk("abort_led", 32'(led), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_step", 32'(step_idx), 0);
    repeat (3) @(negedge CLOCK_50);
    reset = 0;
    sp_done = 0;
    sp_led = 0;
    repeat (150) begin
      @(negedge CLOCK_50);
      sp_done += int'(done);
      sp_led += int'(led != 4'd0 || busy);
    end
    chk("abort_no_done", sp_done, 0);
    chk("abort_stays_idle", sp_led, 0);
    q.delete();
    mon_en = 1;
    push_run(16'h0001, 3);
    arm_start(2'd3, 5'd3, 16'h0001, -1);
    finish_run(3, "after_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
